// File: rtl/fp16_dot_seq.sv
// Operand sequencer for the FP16 MAC: clears the MAC, streams A/B pairs (or +0 bubbles),
// waits for the multiplier pipeline to drain, then returns the accumulated FP16 result.
module fp16_dot_seq #(
    parameter int MUL_LAT = 5,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic             mac_clr,
    input  logic [15:0]      acc_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DRAIN_W = $clog2(MUL_LAT + 2) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MUL_LAT + 1);

    state_t             state_r;
    logic [LEN_W-1:0]   remaining_r;
    logic [DRAIN_W-1:0] drain_r;
    logic               handshake_s;

    // Handshake, MAC clear and status decode from the current state.
    always_comb begin
        in_ready    = (state_r == RUN) && (remaining_r != {LEN_W{1'b0}});
        handshake_s = in_valid & in_ready;
        mac_clr     = (~rst) | (state_r == CLEAR);
        busy        = (state_r != IDLE);
    end

    // Sequencer FSM with registered MAC operands and result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            remaining_r <= {LEN_W{1'b0}};
            drain_r     <= {DRAIN_W{1'b0}};
            mac_a       <= 16'h0000;
            mac_b       <= 16'h0000;
            res_valid   <= 1'b0;
            res_data    <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    mac_a <= 16'h0000;
                    mac_b <= 16'h0000;
                    if (start) begin
                        if (vec_len != {LEN_W{1'b0}}) begin
                            remaining_r <= vec_len;
                            state_r     <= CLEAR;
                        end else begin
                            res_data  <= 16'h0000;
                            res_valid <= 1'b1;
                            state_r   <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CLEAR: begin
                    mac_a   <= 16'h0000;
                    mac_b   <= 16'h0000;
                    state_r <= RUN;
                end
                RUN: begin
                    if (handshake_s) begin
                        mac_a       <= in_a;
                        mac_b       <= in_b;
                        remaining_r <= remaining_r - LEN_W'(1);
                        if (remaining_r == LEN_W'(1)) begin
                            drain_r <= DRAIN_LOAD;
                            state_r <= DRAIN;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        mac_a <= 16'h0000;
                        mac_b <= 16'h0000;
                    end
                end
                DRAIN: begin
                    mac_a <= 16'h0000;
                    mac_b <= 16'h0000;
                    // Counter reaches zero in the cycle the last product has landed in the accumulator.
                    if (drain_r == {DRAIN_W{1'b0}}) begin
                        res_data  <= acc_in;
                        res_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        drain_r <= drain_r - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    mac_a <= 16'h0000;
                    mac_b <= 16'h0000;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        res_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mac_a     <= 16'h0000;
                    mac_b     <= 16'h0000;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_dot_seq.sv
// Directed bench for fp16_dot_seq with a behavioural FP16 MAC (real arithmetic) and
// a queue of expected results popped whenever the sequencer presents a result.
module tb_fp16_dot_seq;
    localparam int MUL_LAT = 5;
    localparam int LEN_W   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] vec_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = 16'h0000;
    logic [15:0]      in_b = 16'h0000;
    logic [15:0]      mac_a, mac_b;
    logic             mac_clr;
    logic [15:0]      acc_in;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_hs = 0;
    int seen = 0;
    logic [15:0] exp_q[$];

    fp16_dot_seq #(.MUL_LAT(MUL_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .acc_in(acc_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic real f2r(logic [15:0] h);
        real m;
        int e;
        e = int'(h[14:10]);
        m = real'(h[9:0]) / 1024.0;
        if (e == 0) m = m * (2.0 ** (-14));
        else        m = (1.0 + m) * (2.0 ** (e - 15));
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2f(real r);
        logic s;
        real m;
        int e;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0 && e < 30) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1)   begin m = m * 2.0; e--; end
        return {s, 5'(e), 10'($rtoi((m - 1.0) * 1024.0 + 0.5))};
    endfunction

    // MAC model: MUL_LAT-stage product pipeline followed by the accumulator register.
    real pipe [MUL_LAT];
    real acc = 0.0;
    always @(posedge clk) begin
        if (mac_clr) begin
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= 0.0;
            acc <= 0.0;
        end else begin
            acc <= acc + pipe[MUL_LAT-1];
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
            pipe[0] <= f2r(mac_a) * f2r(mac_b);
        end
    end
    assign acc_in = r2f(acc);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int len);
        start   = 1'b1;
        vec_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        if (len != 0) begin
            chk("clr_pulse", {15'd0, mac_clr}, 16'd1);
            @(negedge clk);
            chk("clr_end", {15'd0, mac_clr}, 16'd0);
        end
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        int t;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (!in_ready) chk("in_ready_timeout", {15'd0, in_ready}, 16'd1);
        last_hs = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mac_a_pair", mac_a, a);
        chk("mac_b_pair", mac_b, b);
    endtask

    task automatic wait_valid(input int max);
        int t;
        t = 0;
        while (!res_valid && t < max) begin @(negedge clk); t++; end
        chk("res_valid_timeout", {15'd0, res_valid}, 16'd1);
        seen = cyc;
    endtask

    task automatic take_result(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 16'd0, 16'd1);
            e = 16'hxxxx;
        end else begin
            e = exp_q.pop_front();
        end
        chk(tag, res_data, e);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, {15'd0, res_valid}, 16'd0);
        chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mac_clr", {15'd0, mac_clr}, 16'd1);
        chk("rst_mac_a", mac_a, 16'h0000);
        chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_res_data", res_data, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("run_mac_clr", {15'd0, mac_clr}, 16'd0);

        // 1: basic job, in_valid held high
        exp_q.push_back(16'h4800);
        start_job(3);
        send_pair(16'h3C00, 16'h4000);
        send_pair(16'h4000, 16'h4000);
        send_pair(16'h3800, 16'h4400);
        wait_valid(30);
        chk("basic_latency", 16'(seen - last_hs), 16'd8);
        take_result("basic_res");

        // 2: bubbles between pairs
        exp_q.push_back(16'h4800);
        start_job(3);
        send_pair(16'h3C00, 16'h4000);
        repeat (2) begin
            @(negedge clk);
            chk("gap_mac_a", mac_a, 16'h0000);
            chk("gap_mac_b", mac_b, 16'h0000);
            chk("gap_in_ready", {15'd0, in_ready}, 16'd1);
        end
        send_pair(16'h4000, 16'h4000);
        repeat (2) begin
            @(negedge clk);
            chk("gap_mac_a", mac_a, 16'h0000);
            chk("gap_in_ready", {15'd0, in_ready}, 16'd1);
        end
        send_pair(16'h3800, 16'h4400);
        chk("last_in_ready", {15'd0, in_ready}, 16'd0);
        wait_valid(30);
        chk("bubble_latency", 16'(seen - last_hs), 16'd8);
        take_result("bubble_res");

        // 3: zero length
        exp_q.push_back(16'h0000);
        start_job(0);
        chk("zero_valid", {15'd0, res_valid}, 16'd1);
        chk("zero_no_clr", {15'd0, mac_clr}, 16'd0);
        take_result("zero_res");

        // 4: result backpressure, start ignored in DONE
        exp_q.push_back(16'h4000);
        start_job(1);
        send_pair(16'h3C00, 16'h4000);
        wait_valid(30);
        for (int i = 0; i < 5; i++) begin
            start   = (i == 2);
            vec_len = LEN_W'(3);
            @(negedge clk);
            chk("bp_valid", {15'd0, res_valid}, 16'd1);
            chk("bp_data", res_data, 16'h4000);
            chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
            chk("bp_busy", {15'd0, busy}, 16'd1);
        end
        start = 1'b0;
        take_result("bp_res");
        @(negedge clk);
        chk("bp_start_ignored", {15'd0, busy}, 16'd0);

        // 5: reset mid-RUN, then a fresh job
        start_job(3);
        send_pair(16'h4000, 16'h4000);
        send_pair(16'h4000, 16'h4400);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mr_mac_clr", {15'd0, mac_clr}, 16'd1);
            chk("mr_mac_a", mac_a, 16'h0000);
            chk("mr_busy", {15'd0, busy}, 16'd0);
            chk("mr_in_ready", {15'd0, in_ready}, 16'd0);
            chk("mr_res_valid", {15'd0, res_valid}, 16'd0);
            chk("mr_res_data", res_data, 16'h0000);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'hC000);
        start_job(1);
        send_pair(16'hC000, 16'h3C00);
        wait_valid(30);
        take_result("after_rst_res");

        // 6: back-to-back jobs
        exp_q.push_back(16'h3C00);
        start_job(1);
        send_pair(16'h3C00, 16'h3C00);
        wait_valid(30);
        take_result("b2b_first");
        exp_q.push_back(16'h4600);
        start_job(1);
        send_pair(16'h4000, 16'h4200);
        wait_valid(30);
        take_result("b2b_second");
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
